riscv_dmem_arbiter: RTL
=======================

Name: riscv_dmem_arbiter

Overview:
- Shares the single data-memory port, downstream of the dmem interface, between two requesters.
  - Requester 0: CPU load/store path.
  - Requester 1: debug/DMA master.
- Grants one transfer per cycle using round-robin or fixed priority. Fixed priority has a starvation guard.
- Tracks the owner of each outstanding read and returns the 1-cycle-latency read data only to that requester.

Parameters:
- XLEN, 32, data/address width (matches `XLEN).
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority to requester 0.
- MAX_WAIT, 8, in fixed mode, the number of consecutive cycles requester 1 may be denied before it is force-granted (1..255).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req0_valid  in  1  CPU request valid.
- o_req0_ready  out  1  CPU granted this cycle.
- i_req0_addr  in  XLEN  CPU byte address.
- i_req0_wen  in  1  1 = write, 0 = read.
- i_req0_wr_data  in  XLEN  lane-aligned write data.
- i_req0_byte_sel  in  XLEN/8  byte strobes.
- o_req0_rd_valid  out  1  read data valid for CPU.
- o_req0_rd_data  out  XLEN  read data for CPU.
- i_req1_valid, o_req1_ready, i_req1_addr, i_req1_wen, i_req1_wr_data, i_req1_byte_sel, o_req1_rd_valid, o_req1_rd_data: identical to the req0 ports, for requester 1.
- o_mem_en  out  1  memory access strobe.
- o_mem_addr  out  XLEN  memory address.
- o_mem_wen  out  1  memory write enable.
- o_mem_wr_data  out  XLEN  memory write data.
- o_mem_byte_sel  out  XLEN/8  memory byte strobes.
- i_mem_rd_data  in  XLEN  read data, valid one cycle after a read with o_mem_en=1.

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high.
- Reset values: o_mem_en=0, o_reqN_ready=0, o_reqN_rd_valid=0, o_reqN_rd_data=0.
  - Internal: last_grant=1 (requester 0 wins the first contention), wait_cnt=0, rd_pending=0, rd_owner=0.
- Handshake: a transfer occurs when valid && ready.
  - The requester holds addr/wen/data/byte_sel stable while valid=1 and ready=0.
  - ready is combinational from the valids and the arbitration state; no valid-to-ready dependence on ready.
- Arbitration, computed every cycle:
  - Only one valid: that requester is granted.
  - Both valid, PRIO_MODE=0: grant the requester that is not last_grant. last_grant updates on each handshake.
  - Both valid, PRIO_MODE=1: grant 0, unless wait_cnt==MAX_WAIT, in which case grant 1.
  - wait_cnt increments each cycle req1_valid=1 and req1 is not granted. It clears when req1 is granted or req1_valid=0, and saturates at MAX_WAIT.
  - Neither valid: no grant. o_mem_en=0 and o_mem_addr/wen/wr_data/byte_sel drive 0.
- Memory side: o_mem_* is a combinational mux of the granted requester's fields; o_mem_en = any grant.
  - Writes complete on the handshake; no response.
- Read tracking:
  - On a read handshake, register rd_pending=1 and rd_owner=granted id.
  - Next cycle: o_req[rd_owner]_rd_valid=1 and o_req[rd_owner]_rd_data=i_mem_rd_data. The other requester's rd_valid=0 and its rd_data holds its last value.
  - rd_pending reloads or clears every cycle, so back-to-back reads sustain throughput 1/cycle, including alternating owners.
  - A return and a new grant in the same cycle are independent.
- Latency:
  - Request to memory: 0 cycles.
  - Read request handshake to rd_valid: 1 cycle.
- Reset mid-operation: a pending read is dropped and no rd_valid is issued the following cycle. Arbitration state returns to reset values.
- Deassertion: a requester deasserting valid without a handshake is legal. No state changes except the wait_cnt clear.

Decomposition:
- riscv_configs.v additions:
  - `XLEN (existing).
  - `ARB_PRIO_RR=0 and `ARB_PRIO_FIXED=1 constants.
  - Requester ID width constant.
- Sub-module riscv_rr_arbiter2: 2-way grant logic containing the last_grant pointer, the wait counter, and the fixed/RR select.
  - Reusable for the imem/dmem shared-bus arbiter.
- The top module holds the mux, the read tag register, and the response demux.

Test Plan:
1. Reset, then req0 read addr 0x10 alone, mem returns 0xDEADBEEF → o_req0_ready=1 in the same cycle; next cycle o_req0_rd_valid=1 and rd_data=0xDEADBEEF; o_req1_rd_valid=0.
2. PRIO_MODE=0, both valid reads for 4 cycles → grants 0,1,0,1; each rd_valid goes to the matching owner one cycle later with the correct data.
3. PRIO_MODE=1, MAX_WAIT=8, both continuously valid → req0 granted 8 cycles, req1 granted on cycle 9, wait_cnt back to 0, req0 resumes.
4. req1 write addr 0x20, data 0x12345678, byte_sel 0b1100 → o_mem_en=1, wen=1, fields passed through in the same cycle; no rd_valid the next cycle.
5. req0 read handshake, then i_rst=1 in the next cycle → no rd_valid; all outputs 0; first contention after reset goes to req0.
6. Neither valid → o_mem_en=0 and all o_mem_* fields 0; both ready outputs 0.

Source files
------------

// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter slice.
// Priority-mode encodings, requester id type, wait-counter width.
package riscv_dmem_arbiter_pkg;

    localparam int ARB_PRIO_RR    = 0;
    localparam int ARB_PRIO_FIXED = 1;

    localparam int REQ_ID_W = 1;
    localparam int WAIT_W   = 8;

    typedef logic [REQ_ID_W-1:0] req_id_t;
    typedef logic [WAIT_W-1:0]   wait_t;

    // Saturating increment used by the starvation counter.
    function automatic wait_t sat_inc(input wait_t v, input wait_t lim);
        return (v >= lim) ? lim : v + wait_t'(1);
    endfunction

endpackage

// File: rtl/riscv_rr_arbiter2.sv
// Two-way grant logic: round-robin or fixed priority with a starvation guard.
// Ports: i_clk, i_rst, i_valid[1:0] in; o_gnt[1:0] one-hot grant, o_gnt_id out.
module riscv_rr_arbiter2
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = ARB_PRIO_RR,
    parameter int MAX_WAIT  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_gnt,
    output req_id_t    o_gnt_id
);

    localparam wait_t WAIT_LIM = wait_t'(MAX_WAIT);

    req_id_t last_q;
    req_id_t last_d;
    wait_t   wait_q;
    wait_t   wait_d;
    logic    pick1;

    always_comb begin
        // Under contention: fixed mode lets requester 1 in only once it
        // has starved for MAX_WAIT cycles; RR alternates away from last.
        if (PRIO_MODE == ARB_PRIO_FIXED) begin
            pick1 = (wait_q == WAIT_LIM);
        end else begin
            pick1 = (last_q == req_id_t'(0));
        end

        o_gnt = 2'b00;
        if (!i_rst) begin
            if (&i_valid) begin
                o_gnt = pick1 ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_valid;
            end
        end

        o_gnt_id = req_id_t'(o_gnt[1]);
        last_d   = (|o_gnt) ? o_gnt_id : last_q;
        wait_d   = (i_valid[1] && !o_gnt[1]) ? sat_inc(wait_q, WAIT_LIM) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // last=1 makes requester 0 win the first contention.
            last_q <= req_id_t'(1);
            wait_q <= '0;
        end else begin
            last_q <= last_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares one data-memory port between the CPU (req0) and a debug/DMA master (req1).
// Ports: reqN valid/ready/addr/wen/wr_data/byte_sel/rd_valid/rd_data, o_mem_* port, i_mem_rd_data.
module riscv_dmem_arbiter
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PRIO_MODE = ARB_PRIO_RR,
    parameter int MAX_WAIT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [XLEN-1:0]   i_req0_addr,
    input  logic              i_req0_wen,
    input  logic [XLEN-1:0]   i_req0_wr_data,
    input  logic [XLEN/8-1:0] i_req0_byte_sel,
    output logic              o_req0_rd_valid,
    output logic [XLEN-1:0]   o_req0_rd_data,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [XLEN-1:0]   i_req1_addr,
    input  logic              i_req1_wen,
    input  logic [XLEN-1:0]   i_req1_wr_data,
    input  logic [XLEN/8-1:0] i_req1_byte_sel,
    output logic              o_req1_rd_valid,
    output logic [XLEN-1:0]   o_req1_rd_data,

    output logic              o_mem_en,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic              o_mem_wen,
    output logic [XLEN-1:0]   o_mem_wr_data,
    output logic [XLEN/8-1:0] o_mem_byte_sel,
    input  logic [XLEN-1:0]   i_mem_rd_data
);

    logic [1:0]      gnt;
    req_id_t         gnt_id;

    logic            rd_pending_q;
    logic            rd_pending_d;
    req_id_t         rd_owner_q;
    req_id_t         rd_owner_d;
    logic [XLEN-1:0] rd_data0_q;
    logic [XLEN-1:0] rd_data1_q;
    logic            rv0;
    logic            rv1;

    riscv_rr_arbiter2 #(
        .PRIO_MODE (PRIO_MODE),
        .MAX_WAIT  (MAX_WAIT)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  ({i_req1_valid, i_req0_valid}),
        .o_gnt    (gnt),
        .o_gnt_id (gnt_id)
    );

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];

    always_comb begin
        o_mem_en       = |gnt;
        o_mem_addr     = '0;
        o_mem_wen      = 1'b0;
        o_mem_wr_data  = '0;
        o_mem_byte_sel = '0;
        if (gnt[0]) begin
            o_mem_addr     = i_req0_addr;
            o_mem_wen      = i_req0_wen;
            o_mem_wr_data  = i_req0_wr_data;
            o_mem_byte_sel = i_req0_byte_sel;
        end else if (gnt[1]) begin
            o_mem_addr     = i_req1_addr;
            o_mem_wen      = i_req1_wen;
            o_mem_wr_data  = i_req1_wr_data;
            o_mem_byte_sel = i_req1_byte_sel;
        end
    end

    // Read tag: reloaded every cycle so back-to-back reads keep 1/cycle.
    assign rd_pending_d = o_mem_en && !o_mem_wen;
    assign rd_owner_d   = gnt_id;

    // Returns are suppressed during reset so a dropped read never surfaces.
    assign rv0 = !i_rst && rd_pending_q && (rd_owner_q == req_id_t'(0));
    assign rv1 = !i_rst && rd_pending_q && (rd_owner_q == req_id_t'(1));

    assign o_req0_rd_valid = rv0;
    assign o_req1_rd_valid = rv1;

    // Non-owner keeps showing its last returned word.
    assign o_req0_rd_data = i_rst ? '0 : (rv0 ? i_mem_rd_data : rd_data0_q);
    assign o_req1_rd_data = i_rst ? '0 : (rv1 ? i_mem_rd_data : rd_data1_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= req_id_t'(0);
            rd_data0_q   <= '0;
            rd_data1_q   <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            if (rv0) begin
                rd_data0_q <= i_mem_rd_data;
            end
            if (rv1) begin
                rd_data1_q <= i_mem_rd_data;
            end
        end
    end

endmodule
